// File: rtl/serial_binary_subtractor_if.sv
// serial_binary_subtractor_if: start/done request bus for the bit-serial subtractor
//   requester drives: start, a (minuend), b (subtrahend), bin (borrow-in)
//   subtractor drives: busy, done, diff (A-B-Bin mod 2^N), bout (borrow-out), v (signed overflow)
interface serial_binary_subtractor_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         v;
  modport master (output start, a, b, bin, input busy, done, diff, bout, v);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, v);
endinterface

// File: rtl/serial_binary_subtractor.sv
// serial_binary_subtractor: computes A-B-Bin one bit per clock, LSB first, through one full-subtractor cell
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, aborts any operation
//   bus  slave side of serial_binary_subtractor_if (start/a/b/bin in; busy/done/diff/bout/v out)
module serial_binary_subtractor #(parameter int N = 4) (
  input logic                      clk,
  input logic                      rst,
  serial_binary_subtractor_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d, bout_q, bout_d, v_q, v_d, d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    v_d     = v_q;
    d       = a_q[0] ^ b_q[0] ^ br_q;
    case (state_q)
      IDLE:
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      SHIFT: begin
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d = {d, res_q[N-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // On the MSB step a_q[0]/b_q[0] are the operand sign bits and d is the result sign bit
        if (cnt_q == LAST) begin
          diff_d  = res_d;
          bout_d  = br_d;
          v_d     = (a_q[0] != b_q[0]) && (d != a_q[0]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.v    = v_q;
endmodule

// File: tb/tb_serial_binary_subtractor.sv
// tb_serial_binary_subtractor: directed and random checks of the serial subtractor against an arithmetic model
module tb_serial_binary_subtractor;
  localparam int N = 4;
  localparam int P = N + 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [N+1:0] last_e = '0;
  serial_binary_subtractor_if #(.N(N)) bus ();
  serial_binary_subtractor #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // Returns {bout, v, diff} from integer arithmetic on the operand values
  function automatic logic [N+1:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    int dd, sa, sb, sd;
    dd = int'(a) - int'(b) - int'(bin);
    sa = int'(a) - (a[N-1] ? (1 << N) : 0);
    sb = int'(b) - (b[N-1] ? (1 << N) : 0);
    sd = sa - sb - int'(bin);
    return {dd < 0, (sd < -(1 << (N-1))) || (sd >= (1 << (N-1))), N'(dd)};
  endfunction
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    logic [N+1:0] e;
    e = ref_sub(a, b, bin);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("busy", 32'(bus.busy), 1);
      chk("done_early", 32'(bus.done), 0);
      chk("hold", 32'({bus.bout, bus.v, bus.diff}), 32'(last_e));
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      bus.bin = 1'($urandom);
      bus.start = (i == 1);
      @(posedge clk);
      @(negedge clk);
    end
    chk("done", 32'(bus.done), 1);
    chk("busy_at_done", 32'(bus.busy), 0);
    chk("result", 32'({bus.bout, bus.v, bus.diff}), 32'(e));
    last_e = e;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_clear", 32'(bus.done), 0);
    chk("idle_after_done", 32'(bus.busy), 0);
  endtask
  initial begin
    logic [N-1:0] ha [3];
    logic [N-1:0] hb [3];
    logic         hbin [3];
    int p;
    int j;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_outs", 32'({bus.bout, bus.v, bus.diff}), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'b0011, 4'b0101, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b1);
    run_op(4'b0101, 4'b0011, 1'b0);
    run_op(4'b1010, 4'b0101, 1'b1);
    run_op(4'b1111, 4'b1111, 1'b1);
    run_op(4'b0111, 4'b1000, 1'b0);
    run_op(4'b1000, 4'b0001, 1'b0);
    for (int i = 0; i < 40; i++)
      run_op(N'($urandom), N'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) begin
      ha[i] = N'($urandom);
      hb[i] = N'($urandom);
      hbin[i] = 1'($urandom);
    end
    bus.start = 1'b1;
    bus.a = ha[0];
    bus.b = hb[0];
    bus.bin = hbin[0];
    for (int c = 0; c < 3 * P; c++) begin
      @(posedge clk);
      @(negedge clk);
      p = c % P;
      j = c / P;
      chk("hs_busy", 32'(bus.busy), 32'(p < N));
      chk("hs_done", 32'(bus.done), 32'(p == N));
      if (p == N) begin
        last_e = ref_sub(ha[j], hb[j], hbin[j]);
        chk("hs_result", 32'({bus.bout, bus.v, bus.diff}), 32'(last_e));
      end
      if ((c + 1) % P == 0 && (c + 1) / P < 3) begin
        bus.a = ha[(c + 1) / P];
        bus.b = hb[(c + 1) / P];
        bus.bin = hbin[(c + 1) / P];
      end else begin
        bus.a = N'($urandom);
        bus.b = N'($urandom);
        bus.bin = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hs_stop", 32'(bus.busy), 0);
    bus.a = 4'b1010;
    bus.b = 4'b0101;
    bus.bin = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_outs", 32'({bus.bout, bus.v, bus.diff}), 0);
    @(negedge clk);
    rst = 1'b0;
    last_e = '0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_done_after_abort", 32'(bus.done), 0);
    end
    run_op(4'b1010, 4'b0101, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
